// File: rtl/bht_write_arbiter.sv
// Single write-port arbiter for the branch history table: merges ID and EXE
// updates through a small coalescing queue and runs the set-by-set clear sweep.
module bht_write_arbiter #(
    parameter int SET_BITS = 4,
    parameter int WAYS     = 4,
    parameter int ENTRY_W  = 22,
    parameter int QDEPTH   = 4
) (
    input  logic                CLK,
    input  logic                nrst,
    input  logic                en,
    input  logic                bht_clear,
    input  logic                exe_wr_req,
    input  logic [SET_BITS-1:0] exe_wr_set,
    input  logic [WAYS-1:0]     exe_wr_way,
    input  logic [ENTRY_W-1:0]  exe_wr_entry,
    input  logic                id_wr_req,
    input  logic [SET_BITS-1:0] id_wr_set,
    input  logic [WAYS-1:0]     id_wr_way,
    input  logic [ENTRY_W-1:0]  id_wr_entry,
    output logic                bht_we,
    output logic [SET_BITS-1:0] bht_set,
    output logic [WAYS-1:0]     bht_way_mask,
    output logic [ENTRY_W-1:0]  bht_entry,
    output logic                init_busy,
    output logic                wr_backpressure
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [SET_BITS-1:0] LAST_SET = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t              state;
    logic [SET_BITS-1:0] sweep_idx;
    logic [CW-1:0]       q_cnt;
    logic [SET_BITS-1:0] q_set   [QDEPTH];
    logic [WAYS-1:0]     q_way   [QDEPTH];
    logic [ENTRY_W-1:0]  q_entry [QDEPTH];

    logic [CW-1:0]       n_cnt;
    logic [SET_BITS-1:0] n_set   [QDEPTH];
    logic [WAYS-1:0]     n_way   [QDEPTH];
    logic [ENTRY_W-1:0]  n_entry [QDEPTH];

    logic                exe_v, issue, exe_push, id_push, p_v, hit;
    logic [SET_BITS-1:0] sel_set, p_set;
    logic [WAYS-1:0]     sel_way, p_way;
    logic [ENTRY_W-1:0]  sel_entry, p_entry;

    assign wr_backpressure = (q_cnt >= CW'(QDEPTH - 1));

    always_comb begin
        // Same set/way from both stages: the younger ID update wins outright.
        exe_v = exe_wr_req && !(id_wr_req && exe_wr_set == id_wr_set && exe_wr_way == id_wr_way);
        issue     = 1'b1;
        exe_push  = exe_v;
        id_push   = id_wr_req;
        sel_set   = q_set[0];
        sel_way   = q_way[0];
        sel_entry = q_entry[0];
        if (q_cnt == '0) begin
            if (exe_v) begin
                sel_set   = exe_wr_set;
                sel_way   = exe_wr_way;
                sel_entry = exe_wr_entry;
                exe_push  = 1'b0;
            end else if (id_wr_req) begin
                sel_set   = id_wr_set;
                sel_way   = id_wr_way;
                sel_entry = id_wr_entry;
                id_push   = 1'b0;
            end else begin
                issue = 1'b0;
            end
        end

        n_set   = q_set;
        n_way   = q_way;
        n_entry = q_entry;
        n_cnt   = q_cnt;
        if (q_cnt != '0) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
                n_set[i]   = q_set[i+1];
                n_way[i]   = q_way[i+1];
                n_entry[i] = q_entry[i+1];
            end
            n_cnt = q_cnt - CW'(1);
        end

        // Coalesce against the post-pop queue so a head leaving this cycle never absorbs data.
        p_v     = 1'b0;
        p_set   = exe_wr_set;
        p_way   = exe_wr_way;
        p_entry = exe_wr_entry;
        hit     = 1'b0;
        for (int r = 0; r < 2; r++) begin
            p_v     = (r == 0) ? exe_push     : id_push;
            p_set   = (r == 0) ? exe_wr_set   : id_wr_set;
            p_way   = (r == 0) ? exe_wr_way   : id_wr_way;
            p_entry = (r == 0) ? exe_wr_entry : id_wr_entry;
            hit     = 1'b0;
            if (p_v) begin
                for (int i = 0; i < QDEPTH; i++) begin
                    if (!hit && i < int'(n_cnt) && n_set[i] == p_set && n_way[i] == p_way) begin
                        n_entry[i] = p_entry;
                        hit        = 1'b1;
                    end
                end
                if (!hit && n_cnt < CW'(QDEPTH)) begin
                    for (int i = 0; i < QDEPTH; i++) begin
                        if (i == int'(n_cnt)) begin
                            n_set[i]   = p_set;
                            n_way[i]   = p_way;
                            n_entry[i] = p_entry;
                        end
                    end
                    n_cnt = n_cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nrst) begin
            state        <= INIT;
            sweep_idx    <= '0;
            q_cnt        <= '0;
            bht_we       <= 1'b0;
            bht_set      <= '0;
            bht_way_mask <= '0;
            bht_entry    <= '0;
            init_busy    <= 1'b1;
        end else if (en) begin
            if (bht_clear) begin
                state     <= INIT;
                sweep_idx <= '0;
                q_cnt     <= '0;
                bht_we    <= 1'b0;
                init_busy <= 1'b1;
            end else begin
                init_busy <= (state == INIT);
                if (state == INIT) begin
                    bht_we       <= 1'b1;
                    bht_set      <= sweep_idx;
                    bht_way_mask <= '1;
                    bht_entry    <= '0;
                    sweep_idx    <= sweep_idx + 1'b1;
                    if (sweep_idx == LAST_SET) state <= RUN;
                end else begin
                    bht_we <= issue;
                    q_cnt  <= n_cnt;
                    if (issue) begin
                        bht_set      <= sel_set;
                        bht_way_mask <= sel_way;
                        bht_entry    <= sel_entry;
                    end
                end
            end
        end else begin
            bht_we <= 1'b0;
        end
    end

    // Queue payload carries no reset; q_cnt alone decides which slots are live.
    always_ff @(posedge CLK) begin
        if (en && !bht_clear && state == RUN) begin
            q_set   <= n_set;
            q_way   <= n_way;
            q_entry <= n_entry;
        end
    end

endmodule

// File: tb/tb_bht_write_arbiter.sv
// Bench for bht_write_arbiter: directed scenarios then random traffic, all
// checked against a queue-based reference model of the arbitration rules.
module tb_bht_write_arbiter;
    localparam int SET_BITS = 4;
    localparam int WAYS     = 4;
    localparam int ENTRY_W  = 22;
    localparam int QDEPTH   = 4;
    localparam int NSETS    = 1 << SET_BITS;

    logic                CLK = 1'b0;
    logic                nrst, en, bht_clear;
    logic                exe_wr_req, id_wr_req;
    logic [SET_BITS-1:0] exe_wr_set, id_wr_set;
    logic [WAYS-1:0]     exe_wr_way, id_wr_way;
    logic [ENTRY_W-1:0]  exe_wr_entry, id_wr_entry;
    logic                bht_we, init_busy, wr_backpressure;
    logic [SET_BITS-1:0] bht_set;
    logic [WAYS-1:0]     bht_way_mask;
    logic [ENTRY_W-1:0]  bht_entry;

    always #5 CLK = ~CLK;

    bht_write_arbiter #(
        .SET_BITS(SET_BITS), .WAYS(WAYS), .ENTRY_W(ENTRY_W), .QDEPTH(QDEPTH)
    ) dut (
        .CLK(CLK), .nrst(nrst), .en(en), .bht_clear(bht_clear),
        .exe_wr_req(exe_wr_req), .exe_wr_set(exe_wr_set), .exe_wr_way(exe_wr_way),
        .exe_wr_entry(exe_wr_entry),
        .id_wr_req(id_wr_req), .id_wr_set(id_wr_set), .id_wr_way(id_wr_way),
        .id_wr_entry(id_wr_entry),
        .bht_we(bht_we), .bht_set(bht_set), .bht_way_mask(bht_way_mask),
        .bht_entry(bht_entry), .init_busy(init_busy), .wr_backpressure(wr_backpressure)
    );

    typedef struct packed {
        logic [SET_BITS-1:0] wset;
        logic [WAYS-1:0]     wway;
        logic [ENTRY_W-1:0]  wentry;
    } wr_t;

    wr_t                 wq[$];
    int                  m_idx;
    bit                  m_run, m_busy, e_we;
    logic [SET_BITS-1:0] e_set;
    logic [WAYS-1:0]     e_mask;
    logic [ENTRY_W-1:0]  e_entry;
    int                  n_checks = 0;
    int                  n_pass   = 0;
    int                  n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one call per clock edge, reading the inputs about to be sampled.
    task automatic model_step();
        wr_t nw[$];
        wr_t p, t;
        bit  hit;
        if (!nrst) begin
            wq.delete();
            m_idx = 0; m_run = 0; m_busy = 1;
            e_we = 0; e_set = '0; e_mask = '0; e_entry = '0;
            return;
        end
        if (!en) begin
            e_we = 0;
            return;
        end
        if (bht_clear) begin
            wq.delete();
            m_idx = 0; m_run = 0; m_busy = 1; e_we = 0;
            return;
        end
        m_busy = !m_run;
        if (!m_run) begin
            e_we = 1; e_set = m_idx[SET_BITS-1:0]; e_mask = '1; e_entry = '0;
            m_idx++;
            if (m_idx == NSETS) begin
                m_idx = 0;
                m_run = 1;
            end
            return;
        end
        if (exe_wr_req && !(id_wr_req && exe_wr_set == id_wr_set && exe_wr_way == id_wr_way))
            nw.push_back(wr_t'{exe_wr_set, exe_wr_way, exe_wr_entry});
        if (id_wr_req)
            nw.push_back(wr_t'{id_wr_set, id_wr_way, id_wr_entry});
        e_we = 0;
        if (wq.size() > 0) begin
            p = wq.pop_front();
            e_we = 1;
        end else if (nw.size() > 0) begin
            p = nw.pop_front();
            e_we = 1;
        end
        if (e_we) begin
            e_set = p.wset; e_mask = p.wway; e_entry = p.wentry;
        end
        for (int j = 0; j < nw.size(); j++) begin
            hit = 0;
            for (int i = 0; i < wq.size(); i++) begin
                if (wq[i].wset == nw[j].wset && wq[i].wway == nw[j].wway) begin
                    t = wq[i];
                    t.wentry = nw[j].wentry;
                    wq[i] = t;
                    hit = 1;
                end
            end
            if (!hit && wq.size() < QDEPTH) wq.push_back(nw[j]);
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge CLK);
        #1;
        check({tag, ".we"}, bht_we, e_we);
        if (e_we) begin
            check({tag, ".set"}, bht_set, e_set);
            check({tag, ".mask"}, bht_way_mask, e_mask);
            check({tag, ".entry"}, bht_entry, e_entry);
        end
        check({tag, ".busy"}, init_busy, m_busy);
        check({tag, ".bp"}, wr_backpressure, wq.size() >= QDEPTH - 1);
    endtask

    task automatic drive(input bit xr, input int xs, input int xw, input int xe,
                         input bit ir, input int is, input int iw, input int ie);
        exe_wr_req = xr; exe_wr_set = xs[SET_BITS-1:0]; exe_wr_way = xw[WAYS-1:0];
        exe_wr_entry = xe[ENTRY_W-1:0];
        id_wr_req = ir; id_wr_set = is[SET_BITS-1:0]; id_wr_way = iw[WAYS-1:0];
        id_wr_entry = ie[ENTRY_W-1:0];
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        nrst = 0; en = 1; bht_clear = 0;
        idle();
        cycle("rst0");
        cycle("rst1");
        check("rst.we", bht_we, 0);
        check("rst.set", bht_set, 0);
        check("rst.mask", bht_way_mask, 0);
        check("rst.entry", bht_entry, 0);
        check("rst.busy", init_busy, 1);
        check("rst.bp", wr_backpressure, 0);

        // Sweep after reset; requests during the sweep must be dropped.
        nrst = 1;
        for (int i = 0; i < NSETS; i++) begin
            drive(1, i, 1, 'h3FF, i % 2, i, 2, 'h155);
            cycle("sweep");
            check("sweep.set_k", bht_set, i);
            check("sweep.mask_k", bht_way_mask, 'hF);
            check("sweep.busy_k", init_busy, 1);
        end
        idle();
        cycle("post_sweep");
        check("post_sweep.busy_low", init_busy, 0);
        check("post_sweep.dropped", bht_we, 0);

        drive(1, 3, 'b0010, 'h2AAAAA, 0, 0, 0, 0);
        cycle("exe_only");
        check("exe_only.we_k", bht_we, 1);
        check("exe_only.set_k", bht_set, 3);
        check("exe_only.mask_k", bht_way_mask, 'b0010);
        check("exe_only.entry_k", bht_entry, 'h2AAAAA);
        idle();
        cycle("exe_only.after");
        check("exe_only.empty", bht_we, 0);

        drive(1, 1, 'b0001, 'h11111, 1, 2, 'b0100, 'h22222);
        cycle("pair.t1");
        check("pair.t1_set", bht_set, 1);
        check("pair.t1_entry", bht_entry, 'h11111);
        idle();
        cycle("pair.t2");
        check("pair.t2_we", bht_we, 1);
        check("pair.t2_set", bht_set, 2);
        check("pair.t2_mask", bht_way_mask, 'b0100);
        cycle("pair.t3");

        drive(1, 5, 'b1000, 'h0AAAA, 1, 5, 'b1000, 'h15555);
        cycle("same");
        check("same.entry_id", bht_entry, 'h15555);
        idle();
        cycle("same.after");
        check("same.single", bht_we, 0);

        // Continuous traffic with a repeated set/way that must coalesce.
        drive(1, 6, 1, 'h0A1, 1, 7, 1, 'h0A2);  cycle("stream.a");
        drive(1, 8, 2, 'h0B1, 1, 9, 2, 'h0B2);  cycle("stream.b");
        drive(1, 9, 2, 'h0C1, 1, 10, 4, 'h0C2); cycle("stream.c");
        drive(1, 11, 8, 'h0D1, 1, 12, 8, 'h0D2); cycle("stream.d");
        check("stream.coalesced", bht_entry, 'h0C1);
        check("stream.bp_k", wr_backpressure, 1);
        idle();
        for (int i = 0; i < 4; i++) cycle("stream.drain");
        check("stream.bp_clear", wr_backpressure, 0);

        // Head popping in the same cycle does not absorb a matching request.
        drive(1, 3, 1, 'h0E1, 1, 4, 1, 'h0E2); cycle("head.e");
        drive(1, 4, 1, 'h0F1, 0, 0, 0, 0);     cycle("head.f");
        check("head.f_entry", bht_entry, 'h0E2);
        idle();
        cycle("head.g");
        check("head.g_entry", bht_entry, 'h0F1);
        cycle("head.h");

        // Clear with two entries queued, with an en=0 pause mid-sweep.
        drive(1, 1, 2, 'h101, 1, 2, 2, 'h102); cycle("clr.h");
        drive(1, 3, 2, 'h103, 1, 4, 2, 'h104); cycle("clr.i");
        bht_clear = 1;
        cycle("clr.pulse");
        check("clr.busy_k", init_busy, 1);
        check("clr.we_k", bht_we, 0);
        bht_clear = 0;
        idle();
        for (int i = 0; i < NSETS; i++) begin
            if (i == 8) begin
                en = 0;
                drive(1, 7, 4, 'h777, 1, 8, 4, 'h888);
                for (int k = 0; k < 3; k++) cycle("clr.hold");
                check("clr.hold_we", bht_we, 0);
                en = 1;
                idle();
            end
            cycle("clr.sweep");
            check("clr.sweep_set_k", bht_set, i);
        end
        cycle("clr.done");
        check("clr.done_busy", init_busy, 0);
        check("clr.discarded", bht_we, 0);

        // Random traffic on a narrow set/way space to exercise coalescing.
        for (int n = 0; n < 600; n++) begin
            int  xs, is, xw, iw;
            bit  xr, ir;
            xs = $urandom_range(0, 3);
            is = $urandom_range(0, 3);
            xw = 1 << $urandom_range(0, 1);
            iw = 1 << $urandom_range(0, 1);
            xr = ($urandom_range(0, 2) != 0) && (wq.size() < QDEPTH - 1);
            ir = ($urandom_range(0, 2) != 0) && (wq.size() < QDEPTH - 1);
            drive(xr, xs, xw, $urandom(), ir, is, iw, $urandom());
            en        = ($urandom_range(0, 7) != 0);
            bht_clear = ($urandom_range(0, 99) == 0);
            nrst      = ($urandom_range(0, 299) != 0);
            cycle("rand");
        end
        nrst = 1; en = 1; bht_clear = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
